// File: rtl/icache_bank_lookup_pkg.sv
// Shared types for one instruction-cache bank: address type, per-line tag pair
// and line-data width.
package icache_bank_lookup_pkg;

    localparam int unsigned ICB_ADR_W  = 32;
    localparam int unsigned ICB_DATA_W = 512;
    localparam int unsigned ICB_TAGBIT = 13;
    localparam int unsigned ICB_TAG_W  = ICB_ADR_W - ICB_TAGBIT;

    typedef logic [ICB_ADR_W-1:0] addr_t;
    typedef logic [ICB_TAG_W-1:0] tag_field_t;

    typedef struct packed {
        tag_field_t vtag;
        tag_field_t ptag;
    } cache_tag_t;

    function automatic tag_field_t addr_tag(input addr_t a);
        return a[ICB_ADR_W-1:ICB_TAGBIT];
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Simple dual-port line RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old data.
module icache_data_ram
    import icache_bank_lookup_pkg::*;
#(
    parameter int unsigned WID = ICB_DATA_W,
    parameter int unsigned DEP = 512,
    localparam int unsigned AW = $clog2(DEP)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [WID-1:0] wdata,
    input  logic [AW-1:0]  raddr,
    output logic [WID-1:0] rdata
);

    logic [WID-1:0] mem [DEP];
    logic [WID-1:0] rdata_d;
    logic [WID-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = mem[raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/icache_bank_lookup.sv
// One instruction-cache bank: per-way vtag/ptag store, valid bits, combinational
// hit/way detection and a registered line-data read.
module icache_bank_lookup
    import icache_bank_lookup_pkg::*;
#(
    parameter int unsigned LINES  = 128,
    parameter int unsigned WAYS   = 4,
    parameter int unsigned LOBIT  = 6,
    parameter int unsigned TAGBIT = LOBIT + $clog2(LINES),
    parameter int unsigned ADR_W  = ICB_ADR_W,
    parameter int unsigned DATA_W = ICB_DATA_W,
    localparam int unsigned WAY_W = $clog2(WAYS),
    localparam int unsigned NDX_W = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [WAY_W-1:0]  wway,
    input  logic [ADR_W-1:0]  wvadr,
    input  logic [ADR_W-1:0]  wpadr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADR_W-1:0]  adr,
    input  logic [NDX_W-1:0]  ndx,
    output logic              hit,
    output logic [WAY_W-1:0]  rway,
    output logic              cv,
    output logic [DATA_W-1:0] data_o,
    input  logic              inv_line,
    input  logic              inv_all,
    input  logic              snoop_v,
    input  logic [ADR_W-1:0]  snoop_adr
);

    localparam int unsigned TAG_W = ADR_W - TAGBIT;

    cache_tag_t       tag_mem [WAYS][LINES];
    logic [WAYS-1:0]  valid_q [LINES];
    logic [WAYS-1:0]  valid_d [LINES];
    logic             cv_q;
    logic             cv_d;

    logic [NDX_W-1:0] wndx;
    logic [NDX_W-1:0] sndx;
    logic [TAG_W-1:0] stag;
    logic [TAG_W-1:0] ltag;
    logic [WAYS-1:0]  match;
    logic             found;

    assign wndx = wvadr[TAGBIT-1:LOBIT];
    assign sndx = snoop_adr[TAGBIT-1:LOBIT];
    assign stag = snoop_adr[ADR_W-1:TAGBIT];
    assign ltag = adr[ADR_W-1:TAGBIT];

    // Tag contents are never reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (wr) begin
            tag_mem[wway][wndx] <= '{vtag: wvadr[ADR_W-1:TAGBIT],
                                     ptag: wpadr[ADR_W-1:TAGBIT]};
        end
    end

    // Later assignments win: invalidate, then fill set, then snoop clear.
    // The snoop compares against the ptag stored before this edge.
    always_comb begin
        valid_d = valid_q;
        if (inv_line) begin
            valid_d[wndx] = '0;
        end else if (inv_all) begin
            for (int unsigned l = 0; l < LINES; l++) begin
                valid_d[l] = '0;
            end
        end
        if (wr) begin
            valid_d[wndx][wway] = 1'b1;
        end
        if (snoop_v) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (tag_mem[w][sndx].ptag == stag) begin
                    valid_d[sndx][w] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned l = 0; l < LINES; l++) begin
                valid_q[l] <= '0;
            end
        end else begin
            valid_q <= valid_d;
        end
    end

    always_comb begin
        match = '0;
        rway  = '0;
        found = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            match[w] = valid_q[ndx][w] && (tag_mem[w][ndx].vtag == ltag);
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (match[w] && !found) begin
                rway  = WAY_W'(w);
                found = 1'b1;
            end
        end
        hit  = |match;
        cv_d = hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cv_q <= 1'b0;
        end else begin
            cv_q <= cv_d;
        end
    end

    assign cv = cv_q;

    icache_data_ram #(
        .WID (DATA_W),
        .DEP (WAYS * LINES)
    ) u_data_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr),
        .waddr ({wway, wndx}),
        .wdata (wdata),
        .raddr ({rway, ndx}),
        .rdata (data_o)
    );

    logic unused_bits;
    assign unused_bits = ^{adr[TAGBIT-1:0], wvadr[LOBIT-1:0], wpadr[TAGBIT-1:0],
                           snoop_adr[LOBIT-1:0]};

endmodule

// File: tb/tb_icache_bank_lookup.sv
// Directed bench for icache_bank_lookup: fill, lookup, way priority,
// invalidation, snoop and same-cycle interactions.
module tb_icache_bank_lookup;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wr = 1'b0;
    logic [1:0]   wway = '0;
    logic [31:0]  wvadr = '0;
    logic [31:0]  wpadr = '0;
    logic [511:0] wdata = '0;
    logic [31:0]  adr = '0;
    logic [6:0]   ndx = '0;
    logic         hit;
    logic [1:0]   rway;
    logic         cv;
    logic [511:0] data_o;
    logic         inv_line = 1'b0;
    logic         inv_all = 1'b0;
    logic         snoop_v = 1'b0;
    logic [31:0]  snoop_adr = '0;

    integer checks = 0;
    integer errors = 0;

    logic [511:0] d1, d2, d3, d4, d5;

    icache_bank_lookup #(
        .LINES  (128),
        .WAYS   (4),
        .LOBIT  (6),
        .ADR_W  (32),
        .DATA_W (512)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr        (wr),
        .wway      (wway),
        .wvadr     (wvadr),
        .wpadr     (wpadr),
        .wdata     (wdata),
        .adr       (adr),
        .ndx       (ndx),
        .hit       (hit),
        .rway      (rway),
        .cv        (cv),
        .data_o    (data_o),
        .inv_line  (inv_line),
        .inv_all   (inv_all),
        .snoop_v   (snoop_v),
        .snoop_adr (snoop_adr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [18:0] tag, input logic [6:0] idx);
        return {tag, idx, 6'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [1:0] w, input logic [18:0] vt, input logic [18:0] pt,
                        input logic [6:0] idx, input logic [511:0] d);
        wr    = 1'b1;
        wway  = w;
        wvadr = mk(vt, idx);
        wpadr = mk(pt, idx);
        wdata = d;
        step();
        wr    = 1'b0;
    endtask

    task automatic look(input logic [18:0] vt, input logic [6:0] idx);
        adr = mk(vt, idx);
        ndx = idx;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        look(19'h1234, 7'd5);
        step();
        step();
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %0b want 0", hit); end
        checks++; if (rway !== 2'd0) begin errors++; $display("FAIL reset_rway got %0d want 0", rway); end
        checks++; if (cv !== 1'b0) begin errors++; $display("FAIL reset_cv got %0b want 0", cv); end
        checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data got %h want 0", data_o); end
        rst = 1'b0;
        step();
        look(19'h0, 7'd0);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL post_reset_hit got %0b want 0", hit); end
    endtask

    task automatic test_fill_hit();
        fill(2'd2, 19'h1234, 19'h0ab, 7'd5, d1);
        look(19'h1234, 7'd5);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL fill_hit got %0b want 1", hit); end
        checks++; if (rway !== 2'd2) begin errors++; $display("FAIL fill_rway got %0d want 2", rway); end
        step();
        checks++; if (cv !== 1'b1) begin errors++; $display("FAIL fill_cv got %0b want 1", cv); end
        checks++; if (data_o !== d1) begin errors++; $display("FAIL fill_data got %h want %h", data_o, d1); end
        look(19'h1235, 7'd5);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL wrong_tag_hit got %0b want 0", hit); end
        look(19'h1234, 7'd6);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL wrong_ndx_hit got %0b want 0", hit); end
        step();
        checks++; if (cv !== 1'b0) begin errors++; $display("FAIL miss_cv got %0b want 0", cv); end
    endtask

    task automatic test_way_priority();
        fill(2'd3, 19'h1234, 19'h0ab, 7'd5, d3);
        look(19'h1234, 7'd5);
        checks++; if (rway !== 2'd2) begin errors++; $display("FAIL prio_w2w3 got %0d want 2", rway); end
        fill(2'd1, 19'h1234, 19'h0ab, 7'd5, d2);
        look(19'h1234, 7'd5);
        checks++; if (rway !== 2'd1) begin errors++; $display("FAIL prio_rway got %0d want 1", rway); end
        step();
        checks++; if (data_o !== d2) begin errors++; $display("FAIL prio_data got %h want %h", data_o, d2); end
    endtask

    task automatic test_same_cycle();
        // Overwrite way1/index5 data while looking it up: old data returned.
        wr = 1'b1; wway = 2'd1; wvadr = mk(19'h1234, 7'd5); wpadr = mk(19'h0ab, 7'd5); wdata = d5;
        look(19'h1234, 7'd5);
        checks++; if (rway !== 2'd1) begin errors++; $display("FAIL rdw_rway got %0d want 1", rway); end
        step();
        wr = 1'b0;
        checks++; if (data_o !== d2) begin errors++; $display("FAIL rdw_old_data got %h want %h", data_o, d2); end
        step();
        checks++; if (data_o !== d5) begin errors++; $display("FAIL rdw_new_data got %h want %h", data_o, d5); end
        // Fresh fill at index 9 is not visible in its own cycle.
        wr = 1'b1; wway = 2'd0; wvadr = mk(19'h77, 7'd9); wpadr = mk(19'h77, 7'd9); wdata = d4;
        look(19'h77, 7'd9);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL same_cycle_hit got %0b want 0", hit); end
        step();
        wr = 1'b0;
        #1;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL next_cycle_hit got %0b want 1", hit); end
        step();
        checks++; if (data_o !== d4) begin errors++; $display("FAIL next_cycle_data got %h want %h", data_o, d4); end
    endtask

    task automatic test_inv_line();
        wvadr = mk(19'h0, 7'd5);
        inv_line = 1'b1;
        step();
        inv_line = 1'b0;
        look(19'h1234, 7'd5);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL inv_line_hit got %0b want 0", hit); end
        checks++; if (rway !== 2'd0) begin errors++; $display("FAIL inv_line_rway got %0d want 0", rway); end
        look(19'h77, 7'd9);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL inv_line_other got %0b want 1", hit); end
    endtask

    task automatic test_inv_all();
        fill(2'd2, 19'h55, 19'h55, 7'd20, d1);
        look(19'h55, 7'd20);
        checks++; if (rway !== 2'd2 || hit !== 1'b1) begin errors++; $display("FAIL pre_inv_all got hit=%0b rway=%0d want hit=1 rway=2", hit, rway); end
        inv_all = 1'b1;
        step();
        inv_all = 1'b0;
        look(19'h55, 7'd20);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL inv_all_20 got %0b want 0", hit); end
        look(19'h77, 7'd9);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL inv_all_9 got %0b want 0", hit); end
    endtask

    task automatic test_snoop();
        fill(2'd0, 19'h100, 19'h3000, 7'd7, d1);
        fill(2'd1, 19'h100, 19'h3001, 7'd7, d2);
        look(19'h100, 7'd7);
        checks++; if (rway !== 2'd0) begin errors++; $display("FAIL pre_snoop_rway got %0d want 0", rway); end
        snoop_v = 1'b1; snoop_adr = mk(19'h3000, 7'd7);
        step();
        snoop_v = 1'b0;
        #1;
        checks++; if (hit !== 1'b1 || rway !== 2'd1) begin errors++; $display("FAIL snoop_p got hit=%0b rway=%0d want hit=1 rway=1", hit, rway); end
        snoop_v = 1'b1; snoop_adr = mk(19'h3001, 7'd8);
        step();
        snoop_v = 1'b0;
        #1;
        checks++; if (hit !== 1'b1 || rway !== 2'd1) begin errors++; $display("FAIL snoop_other_ndx got hit=%0b rway=%0d want hit=1 rway=1", hit, rway); end
    endtask

    task automatic test_collisions();
        fill(2'd2, 19'h42, 19'h999, 7'd30, d3);
        look(19'h42, 7'd30);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL coll_pre_hit got %0b want 1", hit); end
        // Fill and matching snoop on the same way/index: snoop clear wins.
        wr = 1'b1; wway = 2'd2; wvadr = mk(19'h42, 7'd30); wpadr = mk(19'h999, 7'd30); wdata = d3;
        snoop_v = 1'b1; snoop_adr = mk(19'h999, 7'd30);
        step();
        wr = 1'b0; snoop_v = 1'b0;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL fill_vs_snoop got %0b want 0", hit); end
        // Fill and inv_line at the same index: fill set wins.
        wr = 1'b1; wway = 2'd3; wvadr = mk(19'h61, 7'd31); wpadr = mk(19'h61, 7'd31); wdata = d4;
        inv_line = 1'b1;
        step();
        wr = 1'b0; inv_line = 1'b0;
        look(19'h61, 7'd31);
        checks++; if (hit !== 1'b1 || rway !== 2'd3) begin errors++; $display("FAIL fill_vs_inv got hit=%0b rway=%0d want hit=1 rway=3", hit, rway); end
    endtask

    initial begin
        d1 = {16{32'ha5a5_0001}};
        d2 = {16{32'h5a5a_0002}};
        d3 = {16{32'hdead_0003}};
        d4 = {16{32'hbeef_0004}};
        d5 = {16{32'hc0de_0005}};
        test_reset();
        test_fill_hit();
        test_way_priority();
        test_same_cycle();
        test_inv_line();
        test_inv_all();
        test_snoop();
        test_collisions();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_bank_lookup.md
# icache_bank_lookup

One bank of a set-associative instruction cache: per-way tag store, valid bits, combinational hit/way detection and a data RAM with registered read. Two instances (even and odd line banks) sit inside the instruction cache front end. The enclosing cache supplies the index, the fill data and the invalidation/snoop controls, and consumes hit, way and line data.

## Interface
- LINES, 128, lines per way; power of two
- WAYS, 4, associativity; power of two
- LOBIT, 6, log2 of line size in bytes
- TAGBIT, LOBIT+log2(LINES) (=13), lowest tag bit
- ADR_W, 32, address width
- DATA_W, 512, line data width
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- wr  in  1  fill strobe
- wway  in  log2(WAYS)  fill way
- wvadr  in  ADR_W  fill virtual address; index is [TAGBIT-1:LOBIT], vtag is [ADR_W-1:TAGBIT]
- wpadr  in  ADR_W  fill physical address; ptag is [ADR_W-1:TAGBIT]
- wdata  in  DATA_W  fill line data
- adr  in  ADR_W  lookup address; only [ADR_W-1:TAGBIT] is compared
- ndx  in  log2(LINES)  lookup index
- hit  out  1  combinational hit
- rway  out  log2(WAYS)  combinational hit way
- cv  out  1  registered hit
- data_o  out  DATA_W  registered line data
- inv_line  in  1  invalidate every way at wvadr index
- inv_all  in  1  invalidate everything
- snoop_v  in  1  snoop strobe
- snoop_adr  in  ADR_W  snoop physical address

## Operation
- Storage per way/line: vtag and ptag (ADR_W-TAGBIT bits each) and one valid bit. Storage per way/line of the data RAM: DATA_W bits at address {way,index}.
- Fill (wr=1): writes vtag, ptag and data at {wway, wvadr index} and sets that valid bit.
- Tag read is asynchronous on ndx. For each way w: match[w] = valid[w][ndx] && vtag[w][ndx]==adr[ADR_W-1:TAGBIT].
- hit = OR of match. rway = lowest-numbered matching way; rway = 0 on miss.
- Data RAM read address = {rway, ndx}. Read is registered into data_o. data_o is loaded every cycle, even on a miss.
- cv is hit registered.
- inv_line: clears valid[all ways][wvadr index]. inv_all: clears all valid bits. inv_line has priority over inv_all.
- Snoop (snoop_v=1): at index snoop_adr[TAGBIT-1:LOBIT], clears the valid bit of every way whose ptag == snoop_adr[ADR_W-1:TAGBIT].
- Valid-bit priority for the same bit in one cycle: snoop clear > fill set > inv_line/inv_all.
- Tag and data contents are not reset. Only valid bits, cv and data_o are reset.

## Timing
- Reset: all valid = 0, cv = 0, data_o = 0. hit = 0 follows combinationally.
- Lookup latency: hit/rway arrive in the same cycle as adr/ndx. data_o and cv arrive one cycle later.
- Fill then lookup: a fill is visible to a lookup starting the cycle after the write edge.
- Fill and lookup of the same {way,index} in the same cycle: the tag/valid compare uses the old values, and data_o returns the old data.
- Invalidate and snoop take effect at the clock edge and are seen by the next cycle's hit.
- Index wraparound: ndx is taken as given. Any carry from index arithmetic is handled by the caller.

## Structure
- Shared package: cache tag struct {vtag, ptag}, address type, and line-data width constant.
- One sub-module, icache_data_ram: simple dual-port RAM with one write port and one registered read port, parameters WID/DEP. Read-during-write returns old data.
- The tag store, valid bits and hit logic live in the top module.

## Test plan
- Reset, then lookup with any adr/ndx → hit=0, rway=0; next cycle cv=0, data_o=0.
- Fill way2, index 5, vtag 0x1234, data D. Next cycle look up ndx 5 with a matching adr → hit=1 and rway=2 in that cycle; one cycle later cv=1 and data_o=D.
- Fill the same vtag at index 5 in way1 and way3 → rway=1.
- After a fill, assert inv_line at index 5 → next lookup at index 5 misses. Separately, inv_all → every previously filled line misses.
- Fill way0, index 7 with ptag P and way1, index 7 with ptag Q. Snoop with ptag P at index 7 → way0 misses, way1 still hits.
- Assert fill and snoop of the same way/index in one cycle with a matching ptag → valid ends at 0.
